// File: rtl/alu_cmd_sequencer_if.sv
// Command/ALU/result bundle for alu_cmd_sequencer.
// Latency: none, this file only groups the wires.
// Backpressure: cmd_valid/cmd_ready upstream, res_valid/res_ready downstream.
// Ports: slave = sequencer side, master = command source, ALU and result consumer side.
interface alu_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic       cmd_use_acc;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_zero;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_zero,
        output res_valid, res_data, res_zero,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_zero,
        input  res_valid, res_data, res_zero,
        output res_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time to an external combinational ALU, returns results.
// Latency: accept at edge N -> operands at N+1 -> res_valid from N+2; one result per 2 cycles sustained.
// Backpressure: cmd_ready = !full; a held result (res_valid && !res_ready) stalls issue of the next command.
// Ports: clk, rst_n (async active-low), bus (alu_cmd_sequencer_if.slave: cmd_*, alu_*, res_*), busy.
// Option: define ALU_SEQ_ACC_EN to add the accumulator so cmd_use_acc can replace operand A.
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_cmd_sequencer_if.slave    bus,
    output logic                  busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // ---------------- command FIFO ----------------
    cmd_t          r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    cmd_t          w_new;
    cmd_t          w_head;

    assign w_full  = (r_count == CW'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    // Full refuses a push even when a pop frees a slot in the same cycle,
    // keeping cmd_ready a pure function of registered state.
    assign w_push  = bus.cmd_valid && !w_full;
    assign bus.cmd_ready = !w_full;

    assign w_new  = '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, use_acc: bus.cmd_use_acc};
    assign w_head = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // ---------------- FSM ----------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_capture;
    logic   w_res_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (!w_empty) w_state_nxt = S_EXEC;
            S_EXEC: w_state_nxt = S_OUT;
            S_OUT:  if (bus.res_ready) w_state_nxt = w_empty ? S_IDLE : S_EXEC;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            S_IDLE: w_pop = !w_empty;
            S_EXEC: w_capture = 1'b1;
            S_OUT: begin
                w_res_valid = 1'b1;
                // Issuing on the handshake edge gives the EXEC/OUT two-cycle cadence.
                w_pop = bus.res_ready && !w_empty;
            end
            default: ;
        endcase
    end

    assign bus.res_valid = w_res_valid;
    assign busy          = !w_empty || (r_state != S_IDLE);

    // ---------------- operand A source ----------------
    logic [7:0] w_op_a;

`ifdef ALU_SEQ_ACC_EN
    logic [7:0] r_acc;

    // A pop only happens after the previous result is captured, so acc is current here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_acc <= '0;
        else if (w_capture) r_acc <= bus.alu_result;
    end

    assign w_op_a = w_head.use_acc ? r_acc : w_head.a;
`else
    logic w_unused_use_acc;
    assign w_unused_use_acc = w_head.use_acc;
    assign w_op_a           = w_head.a;
`endif

    // ---------------- ALU drive and result capture ----------------
    logic [7:0] r_alu_a;
    logic [7:0] r_alu_b;
    logic [2:0] r_alu_op;
    logic [7:0] r_res_data;
    logic       r_res_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_res_data <= '0;
            r_res_zero <= 1'b0;
        end else begin
            if (w_pop) begin
                r_alu_a  <= w_op_a;
                r_alu_b  <= w_head.b;
                r_alu_op <= w_head.op;
            end
            if (w_capture) begin
                r_res_data <= bus.alu_result;
                r_res_zero <= bus.alu_zero;
            end
        end
    end

    assign bus.alu_a    = r_alu_a;
    assign bus.alu_b    = r_alu_b;
    assign bus.alu_op   = r_alu_op;
    assign bus.res_data = r_res_data;
    assign bus.res_zero = r_res_zero;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: models the ALU, keeps a command-queue reference model,
// checks every result cycle against it, plus directed literal expectations.
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
`ifdef ALU_SEQ_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    alu_cmd_sequencer_if bus ();

    alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return {a[6:0], 1'b0};
            default: return {1'b0, a[7:1]};
        endcase
    endfunction

    always_comb begin
        bus.alu_result = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
        bus.alu_zero   = (alu_f(bus.alu_op, bus.alu_a, bus.alu_b) == 8'h00);
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       ua;
    } mcmd_t;

    mcmd_t      q[$];
    logic [7:0] m_acc = 8'h00;
    logic [7:0] res_log[$];
    int         vcyc[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] cm_a;
    logic [7:0] cm_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && bus.res_valid) begin
            if (q.size() == 0) begin
                chk("res_unexpected", 1, 0);
            end else begin
                cm_a = (ACC_EN && q[0].ua) ? m_acc : q[0].a;
                cm_e = alu_f(q[0].op, cm_a, q[0].b);
                chk("alu_a",    bus.alu_a,    cm_a);
                chk("alu_b",    bus.alu_b,    q[0].b);
                chk("alu_op",   bus.alu_op,   q[0].op);
                chk("res_data", bus.res_data, cm_e);
                chk("res_zero", bus.res_zero, cm_e == 8'h00);
                if (bus.res_ready) begin
                    m_acc = cm_e;
                    void'(q.pop_front());
                    res_log.push_back(bus.res_data);
                    vcyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus helpers (drive at posedge + 1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic ua);
        int n;
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_use_acc = ua;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) begin
            chk("push_timeout", 0, 1);
        end else begin
            tick();
            q.push_back('{op: op, a: a, b: b, ua: ua});
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!bus.res_valid && n < 50) begin
            tick();
            n++;
        end
        if (!bus.res_valid) chk("valid_timeout", 0, 1);
    endtask

    task automatic accept_one();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        if (q.size() != 0 || busy) chk("drain_timeout", 0, 1);
        bus.res_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] held;
        logic       acc_now;

        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_a = 8'h00;
        bus.cmd_b = 8'h00; bus.cmd_use_acc = 1'b0; bus.res_ready = 1'b0;

        // reset state
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy",      busy,          0);
        chk("rst_alu_a",     bus.alu_a,     0);
        chk("rst_alu_b",     bus.alu_b,     0);
        chk("rst_alu_op",    bus.alu_op,    0);
        chk("rst_res_data",  bus.res_data,  0);
        chk("rst_res_zero",  bus.res_zero,  0);
        #21 rst_n = 1'b1;
        tick();

        // single ADD: latency pinned with literals
        push(3'd0, 8'h05, 8'h03, 1'b0);
        bus.cmd_valid = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_valid_n0", bus.res_valid, 0);
        tick();
        chk("t1_alu_a",  bus.alu_a,  8'h05);
        chk("t1_alu_op", bus.alu_op, 3'd0);
        chk("t1_valid_n1", bus.res_valid, 0);
        tick();
        chk("t1_valid_n2", bus.res_valid, 1);
        chk("t1_data", bus.res_data, 8'h08);
        chk("t1_zero", bus.res_zero, 0);
        accept_one();
        chk("t1_valid_drop", bus.res_valid, 0);
        chk("t1_idle", busy, 0);

        // SUB to zero
        push(3'd1, 8'h42, 8'h42, 1'b0);
        bus.cmd_valid = 1'b0;
        wait_valid();
        chk("t2_data", bus.res_data, 8'h00);
        chk("t2_zero", bus.res_zero, 1);
        accept_one();

        // 5 back-to-back with res_ready low: 4 stored + 1 issued
        res_log.delete();
        for (int i = 1; i <= 5; i++) push(3'd0, 8'(i), 8'(i), 1'b0);
        chk("t3_full", bus.cmd_ready, 0);
        held = bus.res_data;
        // an offered command while full must be refused (an extra result would be unexpected)
        bus.cmd_op = 3'd4; bus.cmd_a = 8'hEE; bus.cmd_b = 8'h11;
        for (int i = 0; i < 3; i++) tick();
        bus.cmd_valid = 1'b0;
        chk("t3_hold_valid", bus.res_valid, 1);
        chk("t3_hold_data", bus.res_data, held);
        chk("t3_still_full", bus.cmd_ready, 0);
        drain();
        chk("t3_count", res_log.size(), 5);
        for (int i = 0; i < 5 && i < res_log.size(); i++) chk("t3_order", res_log[i], 8'(2 * (i + 1)));

        // accumulator chain
        res_log.delete();
        push(3'd0, 8'h10, 8'h01, 1'b0);
        push(3'd6, 8'h80, 8'h5A, 1'b1);
        drain();
        chk("t4_count", res_log.size(), 2);
        if (res_log.size() == 2) begin
            chk("t4_first",  res_log[0], 8'h11);
            chk("t4_second", res_log[1], ACC_EN ? 8'h22 : 8'h00);
        end

        // throughput with res_ready high
        vcyc.delete();
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            push(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom));
        drain();
        chk("t5_count", vcyc.size(), 8);
        for (int i = 1; i < vcyc.size(); i++) chk("t5_gap", vcyc[i] - vcyc[i-1], 2);

        // reset while a result is held with 2 commands queued
        push(3'd3, 8'h0F, 8'hF0, 1'b0);
        push(3'd2, 8'h3C, 8'h0F, 1'b0);
        push(3'd4, 8'hAA, 8'h55, 1'b0);
        bus.cmd_valid = 1'b0;
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_valid", bus.res_valid, 0);
        chk("t6_busy",  busy, 0);
        chk("t6_ready", bus.cmd_ready, 1);
        chk("t6_data",  bus.res_data, 0);
        chk("t6_alu_a", bus.alu_a, 0);
        q.delete();
        m_acc = 8'h00;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("t6_no_stale", bus.res_valid, 0);
        // acc must have been cleared by reset
        res_log.delete();
        push(3'd0, 8'h77, 8'h05, 1'b1);
        drain();
        chk("t6_acc", (res_log.size() == 1) ? res_log[0] : 8'hXX, ACC_EN ? 8'h05 : 8'h7C);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bus.cmd_valid   = ($urandom_range(0, 9) < 6);
            bus.cmd_op      = 3'($urandom_range(0, 7));
            bus.cmd_a       = 8'($urandom);
            bus.cmd_b       = 8'($urandom);
            bus.cmd_use_acc = 1'($urandom);
            bus.res_ready   = 1'($urandom);
            acc_now = bus.cmd_valid && bus.cmd_ready;
            tick();
            if (acc_now) q.push_back('{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b, ua: bus.cmd_use_acc});
        end
        drain();
        chk("final_empty", q.size(), 0);
        chk("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
